// File: rtl/farm_cache.sv
// farm_cache: direct-mapped, write-back, write-allocate word cache between farm and bridge.
// Define FARM_CACHE_STAT_EN to add saturating hit_cnt/miss_cnt outputs.
module farm_cache #(
    parameter int unsigned IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        C_in_valid,
    input  logic [7:0]  C_addr,
    input  logic        C_r_wb,
    input  logic [31:0] C_data_w,
    output logic        C_out_valid,
    output logic [31:0] C_data_r,
    input  logic        flush,
    output logic        flush_done,
    output logic        B_in_valid,
    output logic [7:0]  B_addr,
    output logic        B_r_wb,
    output logic [31:0] B_data_w,
    input  logic        B_out_valid,
    input  logic [31:0] B_data_r
`ifdef FARM_CACHE_STAT_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    localparam int unsigned TAG_W = 8 - IDX_W;
    localparam int unsigned LINES = 1 << IDX_W;

    typedef enum logic [3:0] {
        StIdle, StLookup, StWbReq, StWbWait, StFillReq, StFillWait, StResp,
        StFlScan, StFlReq, StFlWait, StFlDone
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         addr_q;
    logic               r_wb_q;
    logic [31:0]        wdata_q;
    logic               pend_q, pend_d;
    logic [IDX_W-1:0]   scan_q, scan_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;

    logic [31:0]        data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               victim_dirty;
    logic               latch;
    logic               wr_en;
    logic [31:0]        wr_data;

    assign idx          = addr_q[IDX_W-1:0];
    assign tag          = addr_q[7:IDX_W];
    assign hit          = valid_q[idx] && (tag_mem[idx] == tag);
    assign victim_dirty = valid_q[idx] && dirty_q[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            r_wb_q  <= 1'b0;
            wdata_q <= '0;
            pend_q  <= 1'b0;
            scan_q  <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            scan_q  <= scan_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            if (latch) begin
                addr_q  <= C_addr;
                r_wb_q  <= C_r_wb;
                wdata_q <= C_data_w;
            end
        end
    end

    // Line storage carries no reset; valid_q alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[idx] <= wr_data;
            tag_mem[idx]  <= tag;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        scan_d      = scan_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        latch       = 1'b0;
        wr_en       = 1'b0;
        wr_data     = wdata_q;
        C_out_valid = 1'b0;
        C_data_r    = '0;
        flush_done  = 1'b0;
        B_in_valid  = 1'b0;
        B_addr      = '0;
        B_r_wb      = 1'b0;
        B_data_w    = '0;

        if (flush && state_q != StIdle) pend_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (C_in_valid) begin
                    latch   = 1'b1;
                    state_d = StLookup;
                    if (flush) pend_d = 1'b1;
                end else if (flush || pend_q) begin
                    pend_d  = 1'b0;
                    scan_d  = '0;
                    state_d = StFlScan;
                end
            end
            StLookup: begin
                if (hit) begin
                    if (!r_wb_q) begin
                        wr_en        = 1'b1;
                        dirty_d[idx] = 1'b1;
                    end
                    state_d = StResp;
                end else if (victim_dirty) begin
                    state_d = StWbReq;
                end else if (r_wb_q) begin
                    state_d = StFillReq;
                end else begin
                    wr_en        = 1'b1;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b1;
                    state_d      = StResp;
                end
            end
            StWbReq, StWbWait: begin
                B_in_valid = (state_q == StWbReq);
                B_addr     = {tag_mem[idx], idx};
                B_data_w   = data_mem[idx];
                if (state_q == StWbReq) begin
                    state_d = StWbWait;
                end else if (B_out_valid) begin
                    dirty_d[idx] = 1'b0;
                    if (r_wb_q) begin
                        state_d = StFillReq;
                    end else begin
                        wr_en        = 1'b1;
                        valid_d[idx] = 1'b1;
                        dirty_d[idx] = 1'b1;
                        state_d      = StResp;
                    end
                end
            end
            StFillReq, StFillWait: begin
                B_in_valid = (state_q == StFillReq);
                B_addr     = addr_q;
                B_r_wb     = 1'b1;
                if (state_q == StFillReq) begin
                    state_d = StFillWait;
                end else if (B_out_valid) begin
                    wr_en        = 1'b1;
                    wr_data      = B_data_r;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    state_d      = StResp;
                end
            end
            StResp: begin
                C_out_valid = 1'b1;
                C_data_r    = data_mem[idx];
                state_d     = StIdle;
            end
            StFlScan: begin
                if (valid_q[scan_q] && dirty_q[scan_q]) begin
                    state_d = StFlReq;
                end else if (&scan_q) begin
                    state_d = StFlDone;
                end else begin
                    scan_d = scan_q + IDX_W'(1);
                end
            end
            StFlReq, StFlWait: begin
                B_in_valid = (state_q == StFlReq);
                B_addr     = {tag_mem[scan_q], scan_q};
                B_data_w   = data_mem[scan_q];
                if (state_q == StFlReq) begin
                    state_d = StFlWait;
                end else if (B_out_valid) begin
                    dirty_d[scan_q] = 1'b0;
                    if (&scan_q) begin
                        state_d = StFlDone;
                    end else begin
                        scan_d  = scan_q + IDX_W'(1);
                        state_d = StFlScan;
                    end
                end
            end
            StFlDone: begin
                flush_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef FARM_CACHE_STAT_EN
    logic [15:0] hit_q, miss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state_q == StLookup) begin
            if (hit) begin
                if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
            end else if (miss_q != 16'hFFFF) begin
                miss_q <= miss_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_farm_cache.sv
// Bench for farm_cache: directed scenarios plus random traffic against a line-level cache model
// and a pseudo-DRAM bridge responder with random latency.
module tb_farm_cache;

    logic        clk;
    logic        rst_n;
    logic        C_in_valid;
    logic [7:0]  C_addr;
    logic        C_r_wb;
    logic [31:0] C_data_w;
    logic        C_out_valid;
    logic [31:0] C_data_r;
    logic        flush;
    logic        flush_done;
    logic        B_in_valid;
    logic [7:0]  B_addr;
    logic        B_r_wb;
    logic [31:0] B_data_w;
    logic        B_out_valid;
    logic [31:0] B_data_r;
`ifdef FARM_CACHE_STAT_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    farm_cache #(.IDX_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .C_in_valid (C_in_valid),
        .C_addr     (C_addr),
        .C_r_wb     (C_r_wb),
        .C_data_w   (C_data_w),
        .C_out_valid(C_out_valid),
        .C_data_r   (C_data_r),
        .flush      (flush),
        .flush_done (flush_done),
        .B_in_valid (B_in_valid),
        .B_addr     (B_addr),
        .B_r_wb     (B_r_wb),
        .B_data_w   (B_data_w),
        .B_out_valid(B_out_valid),
        .B_data_r   (B_data_r)
`ifdef FARM_CACHE_STAT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Pseudo DRAM behind the bridge, and the farm-visible memory image it must converge to.
    logic [31:0] dram    [256];
    logic [31:0] ref_mem [256];

    // Line-level model of the cache.
    bit          m_valid [16];
    bit          m_dirty [16];
    logic [3:0]  m_tag   [16];
    int          m_hits;
    int          m_misses;

    logic [7:0]  bw_log  [$];
    logic [31:0] bw_dlog [$];
    logic [7:0]  br_log  [$];

    bit          stall;
    bit          busy;
    int          cnt;
    logic [31:0] rsp_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bridge responder: captures each request, answers after 1..3 cycles unless stalled.
    initial begin
        B_out_valid = 1'b0;
        B_data_r    = '0;
        busy        = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            B_out_valid = 1'b0;
            B_data_r    = '0;
            if (!rst_n) begin
                busy = 1'b0;
            end else if (busy) begin
                if (!stall) begin
                    if (cnt <= 1) begin
                        B_out_valid = 1'b1;
                        B_data_r    = rsp_data;
                        busy        = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end else if (B_in_valid) begin
                if (!B_r_wb) begin
                    dram[B_addr] = B_data_w;
                    bw_log.push_back(B_addr);
                    bw_dlog.push_back(B_data_w);
                    rsp_data = '0;
                end else begin
                    br_log.push_back(B_addr);
                    rsp_data = dram[B_addr];
                end
                busy = 1'b1;
                cnt  = int'($urandom_range(1, 3));
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic req(input logic [7:0] a, input logic rw, input logic [31:0] d, input bit wf);
        int          i;
        logic [3:0]  tg;
        bit          hit, exp_wb, exp_fill;
        logic [7:0]  wb_addr;
        logic [31:0] exp_data;
        int          n;
        logic        got;
        logic [31:0] rdata;
        i        = int'(a[3:0]);
        tg       = a[7:4];
        hit      = m_valid[i] && (m_tag[i] == tg);
        exp_wb   = !hit && m_valid[i] && m_dirty[i];
        exp_fill = !hit && rw;
        wb_addr  = {m_tag[i], a[3:0]};
        exp_data = rw ? ref_mem[a] : d;
        bw_log.delete();
        bw_dlog.delete();
        br_log.delete();

        @(posedge clk);
        #1;
        C_in_valid = 1'b1;
        C_addr     = a;
        C_r_wb     = rw;
        C_data_w   = d;
        flush      = wf;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            C_in_valid = 1'b0;
            flush      = 1'b0;
            n++;
        end while (!C_out_valid && n < 200);
        got   = C_out_valid;
        rdata = C_data_r;

        check("resp_valid", got, 1'b1);
        check("resp_data", rdata, exp_data);
        if (!exp_wb && !exp_fill) check("resp_latency", n, 2);
        check("bridge_wr_cnt", bw_log.size(), exp_wb);
        check("bridge_rd_cnt", br_log.size(), exp_fill);
        if (exp_wb && bw_log.size() > 0) begin
            check("wb_addr", bw_log[0], wb_addr);
            check("wb_data", bw_dlog[0], ref_mem[wb_addr]);
        end
        if (exp_fill && br_log.size() > 0) check("fill_addr", br_log[0], a);

        if (hit) m_hits++;
        else m_misses++;
        if (!rw) begin
            ref_mem[a] = d;
            m_dirty[i] = 1'b1;
        end else if (!hit) begin
            m_dirty[i] = 1'b0;
        end
        m_valid[i] = 1'b1;
        m_tag[i]   = tg;
    endtask

    task automatic run_flush(input bit issue, output int cycles);
        logic [7:0] exp_q [$];
        int         n;
        for (int i = 0; i < 16; i++) begin
            if (m_valid[i] && m_dirty[i]) exp_q.push_back({m_tag[i], 4'(i)});
        end
        bw_log.delete();
        bw_dlog.delete();
        br_log.delete();
        if (issue) begin
            @(posedge clk);
            #1;
            flush = 1'b1;
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            flush = 1'b0;
            n++;
        end while (!flush_done && n < 2000);
        cycles = n;
        check("flush_done", flush_done, 1'b1);
        check("flush_wr_cnt", bw_log.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < bw_log.size(); k++) begin
            check("flush_wr_addr", bw_log[k], exp_q[k]);
            check("flush_wr_data", bw_dlog[k], ref_mem[exp_q[k]]);
        end
        check("flush_rd_cnt", br_log.size(), 0);
        for (int i = 0; i < 16; i++) m_dirty[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    int          cyc;
    int          bad;
    logic [7:0]  ra;
    logic        rw;
    logic [31:0] rd;
    bit          wf;

    initial begin
        rst_n      = 1'b0;
        C_in_valid = 1'b0;
        C_addr     = '0;
        C_r_wb     = 1'b0;
        C_data_w   = '0;
        flush      = 1'b0;
        stall      = 1'b0;
        for (int a = 0; a < 256; a++) dram[a] = $urandom;
        dram[8'h05] = 32'h1234_5678;
        for (int a = 0; a < 256; a++) ref_mem[a] = dram[a];
        model_reset();

        #1;
        check("rst_c_out", {C_out_valid, flush_done, B_in_valid, B_r_wb}, 0);
        check("rst_c_data", C_data_r, 0);
        check("rst_b_addr", B_addr, 0);
        check("rst_b_data", B_data_w, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Read miss then read hit
        req(8'h05, 1'b1, 32'h0, 1'b0);
        req(8'h05, 1'b1, 32'h0, 1'b0);
`ifdef FARM_CACHE_STAT_EN
        check("stat_hit_s1", hit_cnt, 1);
        check("stat_miss_s1", miss_cnt, 1);
`endif
        // Write hit, then conflicting read forces write-back
        req(8'h05, 1'b0, 32'hDEAD_BEEF, 1'b0);
        req(8'h15, 1'b1, 32'h0, 1'b0);
        // Write miss to an invalid index installs without bridge traffic
        req(8'h22, 1'b0, 32'hA5A5_0022, 1'b0);
        // Dirty lines at 2, 7, 9 then flush; second flush is a pure scan
        req(8'h37, 1'b0, 32'h0000_0037, 1'b0);
        req(8'h49, 1'b0, 32'h0000_0049, 1'b0);
        run_flush(1'b1, cyc);
        run_flush(1'b1, cyc);
        check("empty_flush_cycles", cyc, 17);
        // Flush coinciding with a request
        req(8'h6A, 1'b0, 32'h6A6A_6A6A, 1'b1);
        run_flush(1'b0, cyc);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 19) == 0) run_flush(1'b1, cyc);
            ra = 8'($urandom_range(0, 63));
            rw = 1'($urandom_range(0, 1));
            rd = $urandom;
            wf = ($urandom_range(0, 24) == 0);
            req(ra, rw, rd, wf);
            if (wf) run_flush(1'b0, cyc);
        end
`ifdef FARM_CACHE_STAT_EN
        check("stat_hit_rand", hit_cnt, m_hits);
        check("stat_miss_rand", miss_cnt, m_misses);
`endif
        run_flush(1'b1, cyc);
        bad = 0;
        for (int a = 0; a < 256; a++) if (dram[a] !== ref_mem[a]) bad++;
        check("dram_image_bad_words", bad, 0);

        // Reset while a fill is outstanding
        stall = 1'b1;
        @(posedge clk);
        #1;
        C_in_valid = 1'b1;
        C_addr     = 8'hC3;
        C_r_wb     = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            C_in_valid = 1'b0;
            cyc++;
        end while (!B_in_valid && cyc < 20);
        check("s6_fill_req", B_in_valid, 1'b1);
        @(posedge clk);
        #2;
        check("s6_fill_wait_addr", B_addr, 8'hC3);
        check("s6_fill_wait_rwb", B_r_wb, 1'b1);
        rst_n = 1'b0;
        #1;
        check("s6_rst_flags", {C_out_valid, flush_done, B_in_valid, B_r_wb}, 0);
        check("s6_rst_b_addr", B_addr, 0);
        check("s6_rst_c_data", C_data_r, 0);
        check("s6_rst_b_data", B_data_w, 0);
        @(posedge clk);
        @(posedge clk);
        #1 stall = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        req(8'hC3, 1'b1, 32'h0, 1'b0);
`ifdef FARM_CACHE_STAT_EN
        check("stat_hit_s6", hit_cnt, 0);
        check("stat_miss_s6", miss_cnt, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
